// File: rtl/sseg_scan_driver.sv
// Time-multiplexed seven-segment scan driver.
// Payload loads are staged and promoted to the displayed set only at the frame
// boundary, so a frame never mixes old and new data. Anodes and cathodes are
// active-low and registered.
module sseg_scan_driver #(
    parameter int N_DIGITS     = 8,
    parameter int DWELL_CYCLES = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp_mask,
    input  logic [N_DIGITS-1:0]     blank_mask,
    input  logic                    lz_en,
    input  logic [2:0]              brightness,
    output logic [N_DIGITS-1:0]     an,
    output logic [7:0]              sseg,
    output logic                    frame_tick
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]        dwell_cnt_q, dwell_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    dwell_last, frame_last;
    logic                    frame_start_q;

    logic [4*N_DIGITS-1:0]   stg_value_q, act_value_q;
    logic [N_DIGITS-1:0]     stg_dp_q, act_dp_q;
    logic [N_DIGITS-1:0]     stg_blank_q, act_blank_q;
    logic                    stg_lz_q, act_lz_q;
    logic                    pending_q;

    logic [N_DIGITS-1:0]     upper_zero;
    logic [3:0]              nib;
    logic [31:0]             on_window;
    logic                    digit_blank, driven;
    logic [N_DIGITS-1:0]     an_d, an_q;
    logic [7:0]              sseg_d, sseg_q;
    logic                    frame_tick_q;

    // Hex nibble to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    // Dwell counter and digit index advance; frame_last marks the 7->0 wrap cycle
    always_comb begin
        dwell_last  = (dwell_cnt_q == CNT_LAST);
        frame_last  = dwell_last && (idx_q == IDX_LAST);
        dwell_cnt_d = dwell_last ? '0 : dwell_cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        if (dwell_last) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Scan position registers; frame_start_q flags the first cycle of a new frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt_q   <= '0;
            idx_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            dwell_cnt_q   <= dwell_cnt_d;
            idx_q         <= idx_d;
            frame_start_q <= frame_last;
        end
    end

    // Staging capture: last load wins, pending holds until the frame boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_value_q <= '0;
            stg_dp_q    <= '0;
            stg_blank_q <= '0;
            stg_lz_q    <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            if (load) begin
                stg_value_q <= value;
                stg_dp_q    <= dp_mask;
                stg_blank_q <= blank_mask;
                stg_lz_q    <= lz_en;
            end
            if (load) begin
                pending_q <= 1'b1;
            end else if (frame_last) begin
                pending_q <= 1'b0;
            end
        end
    end

    // Promote staging to the displayed set on the boundary cycle only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_value_q <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '0;
            act_lz_q    <= 1'b0;
        end else if (frame_last && pending_q) begin
            act_value_q <= stg_value_q;
            act_dp_q    <= stg_dp_q;
            act_blank_q <= stg_blank_q;
            act_lz_q    <= stg_lz_q;
        end
    end

    // Pin values for the current scan position: visibility, PWM window, decode
    always_comb begin
        nib = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            upper_zero[i] = ((act_value_q >> (4 * i)) == '0);
            if (idx_q == IDX_W'(i)) begin
                nib = act_value_q[4*i +: 4];
            end
        end
        on_window   = ((32'(brightness) + 32'd1) * 32'(DWELL_CYCLES)) >> 3;
        digit_blank = act_blank_q[idx_q] ||
                      (act_lz_q && (idx_q != '0) && upper_zero[idx_q]);
        driven      = !digit_blank && (32'(dwell_cnt_q) < on_window);
        an_d        = '1;
        sseg_d      = 8'hFF;
        if (driven) begin
            an_d   = ~(N_DIGITS'(1) << idx_q);
            sseg_d = {~act_dp_q[idx_q], seg_decode(nib)};
        end
    end

    // Registered pins, dark while in reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q         <= '1;
            sseg_q       <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            an_q         <= an_d;
            sseg_q       <= sseg_d;
            frame_tick_q <= frame_start_q;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_tick = frame_tick_q;

endmodule
